// File: rtl/fsm_start_seq.sv
// Start sequencer: pulses start[i] for each downstream stage in order, waiting for done[i] before moving on.
// Define FSM_START_SEQ_TIMEOUT_EN to add a per-stage done-wait timeout that lands in ERROR.
module fsm_start_seq #(
    parameter int NUM_STAGES     = 3,
    parameter int START_DELAY    = 0,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  restart,
    input  logic [NUM_STAGES-1:0] done,
    output logic [NUM_STAGES-1:0] start,
    output logic [IW-1:0]         stage_idx,
    output logic                  busy,
    output logic                  all_done,
    output logic                  error
);

    typedef enum logic [2:0] {
        S_DELAY    = 3'd0,
        S_PULSE    = 3'd1,
        S_WAIT     = 3'd2,
        S_FINISHED = 3'd3,
        S_ERROR    = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [7:0]              dly_q, dly_d;
    logic [NUM_STAGES-1:0]   start_q, start_d;
    logic                    busy_q, busy_d;
    logic                    all_done_q, all_done_d;
    logic                    done_sel;
`ifdef FSM_START_SEQ_TIMEOUT_EN
    logic [15:0]             to_q, to_d;
    logic                    error_q, error_d;
`endif

    // Only the done bit of the stage currently being waited on matters.
    always_comb begin
        done_sel = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (idx_q == IW'(i)) begin
                done_sel = done_sel | done[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_DELAY;
            idx_q      <= '0;
            dly_q      <= '0;
            start_q    <= '0;
            busy_q     <= 1'b1;
            all_done_q <= 1'b0;
`ifdef FSM_START_SEQ_TIMEOUT_EN
            to_q       <= '0;
            error_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dly_q      <= dly_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            all_done_q <= all_done_d;
`ifdef FSM_START_SEQ_TIMEOUT_EN
            to_q       <= to_d;
            error_q    <= error_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        dly_d   = dly_q;
`ifdef FSM_START_SEQ_TIMEOUT_EN
        to_d    = to_q;
`endif
        case (state_q)
            S_DELAY: begin
                if (dly_q == 8'(START_DELAY)) begin
                    state_d = S_PULSE;
                end else begin
                    dly_d = dly_q + 8'd1;
                end
            end
            S_PULSE: begin
                state_d = S_WAIT;
`ifdef FSM_START_SEQ_TIMEOUT_EN
                to_d    = '0;
`endif
            end
            S_WAIT: begin
                if (done_sel) begin
                    if (idx_q == IW'(NUM_STAGES - 1)) begin
                        state_d = S_FINISHED;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = S_PULSE;
                    end
                end
`ifdef FSM_START_SEQ_TIMEOUT_EN
                else if (to_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ERROR;
                end else begin
                    to_d = to_q + 16'd1;
                end
`endif
            end
            S_FINISHED, S_ERROR: begin
                if (restart) begin
                    state_d = S_DELAY;
                    idx_d   = '0;
                    dly_d   = '0;
                end
            end
            default: begin
                state_d = S_DELAY;
                idx_d   = '0;
                dly_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        start_d = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            start_d[i] = (state_d == S_PULSE) && (idx_d == IW'(i));
        end
        busy_d     = (state_d == S_DELAY) || (state_d == S_PULSE) || (state_d == S_WAIT);
        all_done_d = (state_d == S_FINISHED);
`ifdef FSM_START_SEQ_TIMEOUT_EN
        error_d    = (state_d == S_ERROR);
`endif
    end

    assign start     = start_q;
    assign stage_idx = idx_q;
    assign busy      = busy_q;
    assign all_done  = all_done_q;
`ifdef FSM_START_SEQ_TIMEOUT_EN
    assign error     = error_q;
`else
    assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_start_seq.sv
// Directed bench for fsm_start_seq: a 3-stage/delay-2 instance and a 1-stage/delay-0 instance.
module tb_fsm_start_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       restart_a = 1'b0;
    logic [2:0] done_a = 3'b000;
    logic [2:0] start_a;
    logic [1:0] idx_a;
    logic       busy_a, all_done_a, error_a;

    logic       restart_b = 1'b0;
    logic [0:0] done_b = 1'b0;
    logic [0:0] start_b;
    logic [0:0] idx_b;
    logic       busy_b, all_done_b, error_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fsm_start_seq #(.NUM_STAGES(3), .START_DELAY(2), .TIMEOUT_CYCLES(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .restart(restart_a), .done(done_a),
        .start(start_a), .stage_idx(idx_a), .busy(busy_a),
        .all_done(all_done_a), .error(error_a)
    );

    fsm_start_seq #(.NUM_STAGES(1), .START_DELAY(0), .TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .restart(restart_b), .done(done_b),
        .start(start_b), .stage_idx(idx_b), .busy(busy_b),
        .all_done(all_done_b), .error(error_b)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        chk("rst_start",    8'(start_a),    8'h0);
        chk("rst_busy",     8'(busy_a),     8'h1);
        chk("rst_all_done", 8'(all_done_a), 8'h0);
        chk("rst_error",    8'(error_a),    8'h0);
        chk("rst_idx",      8'(idx_a),      8'h0);

        rst_n = 1'b1;
        tick();
        chk("a_c1_start", 8'(start_a), 8'h0);
        chk("b_first_start", 8'(start_b), 8'h1);
        tick();
        chk("a_c2_start", 8'(start_a), 8'h0);
        chk("b_pulse_width", 8'(start_b), 8'h0);
        done_b = 1'b1;
        tick();
        chk("a_first_start", 8'(start_a), 8'h1);
        chk("a_first_idx",   8'(idx_a),   8'h0);
        chk("b_all_done",    8'(all_done_b), 8'h1);
        chk("b_busy",        8'(busy_b),  8'h0);
        chk("b_idx",         8'(idx_b),   8'h0);
        done_b = 1'b0;

        // done[0] during the pulse cycle must be ignored
        done_a = 3'b001;
        tick();
        done_a = 3'b000;
        chk("a_pulse_width", 8'(start_a), 8'h0);
        chk("a_pulse_done_busy", 8'(busy_a), 8'h1);
        chk("a_pulse_done_idx",  8'(idx_a),  8'h0);

        // Other stages' done bits ignored while waiting on stage 0
        done_a = 3'b110;
        tick(3);
        chk("a_other_done_idx",   8'(idx_a),   8'h0);
        chk("a_other_done_start", 8'(start_a), 8'h0);
        chk("a_other_done_busy",  8'(busy_a),  8'h1);
        done_a = 3'b000;
        tick();

        done_a = 3'b001;
        tick();
        done_a = 3'b000;
        chk("a_start1", 8'(start_a), 8'h2);
        chk("a_idx1",   8'(idx_a),   8'h1);
        tick();
        chk("a_start1_width", 8'(start_a), 8'h0);
        tick(3);

        done_a = 3'b010;
        tick();
        done_a = 3'b000;
        chk("a_start2", 8'(start_a), 8'h4);
        chk("a_idx2",   8'(idx_a),   8'h2);

        // restart while busy is ignored
        restart_a = 1'b1;
        tick(2);
        restart_a = 1'b0;
        chk("a_restart_ign_idx",  8'(idx_a),  8'h2);
        chk("a_restart_ign_busy", 8'(busy_a), 8'h1);
        tick(2);

        done_a = 3'b100;
        tick();
        done_a = 3'b000;
        chk("a_fin_all_done", 8'(all_done_a), 8'h1);
        chk("a_fin_busy",     8'(busy_a),     8'h0);
        chk("a_fin_start",    8'(start_a),    8'h0);
        tick(2);
        chk("a_fin_hold", 8'(all_done_a), 8'h1);

        // Accepted restart reruns the sequence
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        chk("a_rs_all_done", 8'(all_done_a), 8'h0);
        chk("a_rs_busy",     8'(busy_a),     8'h1);
        chk("a_rs_idx",      8'(idx_a),      8'h0);
        tick(2);
        chk("a_rs_delay_start", 8'(start_a), 8'h0);
        tick();
        chk("a_rs_start0", 8'(start_a), 8'h1);
        tick();
        done_a = 3'b001;
        tick();
        done_a = 3'b000;
        chk("a_rs_start1", 8'(start_a), 8'h2);

        // Reset mid-sequence kills the pulse immediately
        rst_n = 1'b0;
        #1;
        chk("a_mid_rst_start",    8'(start_a),    8'h0);
        chk("a_mid_rst_idx",      8'(idx_a),      8'h0);
        chk("a_mid_rst_busy",     8'(busy_a),     8'h1);
        chk("a_mid_rst_all_done", 8'(all_done_a), 8'h0);
        chk("a_mid_rst_error",    8'(error_a),    8'h0);
        tick();
        rst_n = 1'b1;
        tick(2);
        chk("a_rr_delay_start", 8'(start_a), 8'h0);
        tick();
        chk("a_rr_start0", 8'(start_a), 8'h1);
        tick();
        done_a = 3'b001;
        tick();
        done_a = 3'b000;
        chk("a_rr_start1", 8'(start_a), 8'h2);

`ifdef FSM_START_SEQ_TIMEOUT_EN
        tick(16);
        chk("a_to_pre_error", 8'(error_a), 8'h0);
        chk("a_to_pre_busy",  8'(busy_a),  8'h1);
        tick();
        chk("a_to_error",    8'(error_a),    8'h1);
        chk("a_to_busy",     8'(busy_a),     8'h0);
        chk("a_to_idx",      8'(idx_a),      8'h1);
        chk("a_to_all_done", 8'(all_done_a), 8'h0);
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        chk("a_to_rs_error", 8'(error_a), 8'h0);
        chk("a_to_rs_idx",   8'(idx_a),   8'h0);
        tick(3);
        chk("a_to_rs_start0", 8'(start_a), 8'h1);
`else
        tick(40);
        chk("a_nto_error", 8'(error_a), 8'h0);
        chk("a_nto_busy",  8'(busy_a),  8'h1);
        chk("a_nto_idx",   8'(idx_a),   8'h1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fsm_start_seq.md
FSM_START_SEQ -- requirements
Module: fsm_start_seq

Interface
REQ-001 Parameter NUM_STAGES, default 3: number of downstream stages to sequence; legal range 1..8.
REQ-002 Parameter START_DELAY, default 0: idle cycles after reset release or restart before the first start pulse; legal range 0..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024: done-wait limit, used only when FSM_START_SEQ_TIMEOUT_EN is defined; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 restart  input  1  level-sampled request to rerun the sequence.
REQ-007 done  input  NUM_STAGES  per-stage completion flags; bit i belongs to stage i.
REQ-008 start  output  NUM_STAGES  per-stage one-cycle start pulses.
REQ-009 stage_idx  output  max(1,$clog2(NUM_STAGES))  index of the current stage.
REQ-010 busy  output  1  sequence in progress.
REQ-011 all_done  output  1  every stage has completed.
REQ-012 error  output  1  a stage timed out; the port is present in both builds.

Function
REQ-013 States SHALL be DELAY, PULSE, WAIT_DONE, FINISHED and ERROR; all outputs SHALL be registered.
REQ-014 DELAY SHALL count START_DELAY cycles, then go to PULSE. The first start pulse SHALL therefore be high in the cycle that begins START_DELAY+1 rising edges after reset release or after restart is accepted.
REQ-015 PULSE SHALL assert start[stage_idx] for exactly one cycle with all other start bits low, then go to WAIT_DONE.
REQ-016 done[stage_idx] high in the PULSE cycle SHALL be ignored; only done sampled in WAIT_DONE counts.
REQ-017 In WAIT_DONE, done[stage_idx] high with stage_idx < NUM_STAGES-1 SHALL increment stage_idx and enter PULSE, so the next start is high in the cycle after done.
REQ-018 In WAIT_DONE, done[stage_idx] high with stage_idx = NUM_STAGES-1 SHALL enter FINISHED.
REQ-019 done bits of any other stage SHALL be ignored in every state.
REQ-020 busy SHALL be 1 in DELAY, PULSE and WAIT_DONE, and 0 otherwise.
REQ-021 all_done SHALL be 1 only in FINISHED and SHALL hold until a restart is accepted.
REQ-022 restart SHALL be accepted only in FINISHED or ERROR. Acceptance clears stage_idx, the delay counter, all_done and error on the next edge and enters DELAY.
REQ-023 restart SHALL be ignored in DELAY, PULSE and WAIT_DONE.
REQ-024 With NUM_STAGES=1, stage_idx SHALL stay 0 and one done SHALL complete the sequence.

Reset
REQ-025 rst_n low SHALL immediately force state DELAY, stage_idx 0, all counters 0, start 0, all_done 0 and error 0.
REQ-026 busy SHALL read 1 while rst_n is low.
REQ-027 Reset asserted mid-sequence SHALL abort with no start pulse in the reset cycle. After release the sequence SHALL restart from stage 0.

Configuration
REQ-028 With FSM_START_SEQ_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT_DONE and increment each WAIT_DONE cycle. If it reaches TIMEOUT_CYCLES without done, the block SHALL enter ERROR with error=1, busy=0, all_done=0 and stage_idx frozen at the failing stage.
REQ-029 With FSM_START_SEQ_TIMEOUT_EN undefined, WAIT_DONE SHALL wait indefinitely, ERROR SHALL be unreachable, error SHALL be tied 0 and no timeout counter SHALL be synthesised.

Verification
REQ-030 NUM_STAGES=3, START_DELAY=2, release rst_n, done[i] pulsed 5 cycles after each start[i] -> start[0] high in the 3rd cycle after release, each start exactly 1 cycle wide, start[i+1] one cycle after done[i], all_done=1 and busy=0 after done[2].
REQ-031 START_DELAY=0, NUM_STAGES=1 -> start[0] high in the first cycle after release; done[0] -> all_done=1.
REQ-032 done[1] and done[2] asserted while waiting on stage 0 -> no state change and stage_idx stays 0; done[0] asserted during the start[0] pulse -> ignored, busy stays 1.
REQ-033 rst_n driven low during WAIT_DONE of stage 1 -> start, all_done and error all 0 immediately; after release the sequence reruns from start[0].
REQ-034 After FINISHED, restart held 1 cycle -> all_done=0 on the next edge and the full sequence repeats; restart held during WAIT_DONE -> ignored.
REQ-035 Timeout build, TIMEOUT_CYCLES=16, done[1] never asserted -> error=1 and stage_idx=1 after 16 WAIT_DONE cycles; restart then clears error and restarts from stage 0.
